// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: serial multi-nibble adder built around one 4-bit
// look-ahead carry slice. Each RUN cycle adds one nibble and keeps the carry
// in a register for the next cycle. Operands come in on a valid/ready
// handshake, and the result goes out on a second valid/ready handshake.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Cout,
    output logic                   Overflow
);

    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned CntW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;

    logic [3:0]        slice_g, slice_p, slice_sum;
    logic [4:0]        slice_c;
    logic [WIDTH-1:0]  sum_shift;

    // 4-bit look-ahead carry slice on the low nibble of the shift registers
    always_comb begin
        slice_g    = a_sh_q[3:0] & b_sh_q[3:0];
        slice_p    = a_sh_q[3:0] ^ b_sh_q[3:0];
        slice_c[0] = carry_q;
        slice_c[1] = slice_g[0] | (slice_p[0] & carry_q);
        slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
                   | (slice_p[1] & slice_p[0] & carry_q);
        slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
                   | (slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
        slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2])
                   | (slice_p[3] & slice_p[2] & slice_g[1])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
        slice_sum  = slice_p ^ slice_c[3:0];
    end

    // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom
    if (NIBBLES == 1) begin : g_one
        assign sum_shift = slice_sum;
    end else begin : g_many
        assign sum_shift = {slice_sum, sum_sh_q[WIDTH-1:4]};
    end

    // Next-state and datapath update; everything holds unless the state acts on it
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_sh_d = sum_shift;
                a_sh_d   = a_sh_q >> 4;
                b_sh_d   = b_sh_q >> 4;
                carry_d  = slice_c[4];
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    // Handshake and result outputs; results read as zero unless out_valid is high
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        Sum       = out_valid ? sum_sh_q : '0;
        Cout      = out_valid & carry_q;
        Overflow  = out_valid & (a_msb_q == b_msb_q) & (sum_sh_q[WIDTH-1] != a_msb_q);
    end

endmodule
